// File: rtl/vga_scanout.sv
// VGA 640x480 scanout: timing generator plus ping-pong bank unpacker feeding the DAC.
// Optional colour-bar source (adds test_mode input) when VGA_TEST_PATTERN_EN is defined.
module vga_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pix_en,
    input  logic [127:0] r_reg_a,
    input  logic [127:0] g_reg_a,
    input  logic [127:0] b_reg_a,
    input  logic [127:0] r_reg_b,
    input  logic [127:0] g_reg_b,
    input  logic [127:0] b_reg_b,
`ifdef VGA_TEST_PATTERN_EN
    input  logic         test_mode,
`endif
    output logic         read_vga_selector,
    output logic [7:0]   vga_r,
    output logic [7:0]   vga_g,
    output logic [7:0]   vga_b,
    output logic         vga_hs,
    output logic         vga_vs,
    output logic         vga_blank_n,
    output logic [9:0]   pos_x,
    output logic [9:0]   pos_y,
    output logic         frame_start
);

    // state      | meaning
    // PH_BLANK   | outside active video: RGB forced to 0, shifters and selector hold
    // PH_LOAD    | first pixel of a 16-pixel word: load from displayed bank, flip selector
    // PH_SHIFT   | remaining pixels of the word come out of the shifters
    typedef enum logic [1:0] {PH_BLANK, PH_LOAD, PH_SHIFT} phase_t;

    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] H_TOT_M1 = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] V_TOT_M1 = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic       SYNC_ACT = (SYNC_POL != 0);

    logic [9:0]   h_cnt, v_cnt;
    logic [127:0] shift_r, shift_g, shift_b;
    logic [127:0] src_r, src_g, src_b;
    logic         active, hs_on, vs_on;
    phase_t       phase;

    assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_on  = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign vs_on  = (v_cnt >= VS_START) && (v_cnt < VS_END);

    // Displayed bank is the one merge is not filling.
    assign src_r = read_vga_selector ? r_reg_b : r_reg_a;
    assign src_g = read_vga_selector ? g_reg_b : g_reg_a;
    assign src_b = read_vga_selector ? b_reg_b : b_reg_a;

    always_comb begin
        phase = PH_BLANK;
        if (active) begin
            phase = (h_cnt[3:0] == 4'd0) ? PH_LOAD : PH_SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt             <= '0;
            v_cnt             <= '0;
            read_vga_selector <= 1'b0;
            shift_r           <= '0;
            shift_g           <= '0;
            shift_b           <= '0;
            vga_r             <= '0;
            vga_g             <= '0;
            vga_b             <= '0;
            vga_hs            <= ~SYNC_ACT;
            vga_vs            <= ~SYNC_ACT;
            vga_blank_n       <= 1'b0;
            pos_x             <= '0;
            pos_y             <= '0;
            frame_start       <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (pix_en) begin
                if (h_cnt == H_TOT_M1) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_TOT_M1) ? 10'd0 : v_cnt + 10'd1;
                end else begin
                    h_cnt <= h_cnt + 10'd1;
                end

                pos_x       <= h_cnt;
                pos_y       <= v_cnt;
                vga_blank_n <= active;
                vga_hs      <= hs_on ? SYNC_ACT : ~SYNC_ACT;
                vga_vs      <= vs_on ? SYNC_ACT : ~SYNC_ACT;
                frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0);

                case (phase)
                    PH_LOAD: begin
                        vga_r             <= src_r[7:0];
                        vga_g             <= src_g[7:0];
                        vga_b             <= src_b[7:0];
                        shift_r           <= src_r >> 8;
                        shift_g           <= src_g >> 8;
                        shift_b           <= src_b >> 8;
                        read_vga_selector <= ~read_vga_selector;
                    end
                    PH_SHIFT: begin
                        vga_r   <= shift_r[7:0];
                        vga_g   <= shift_g[7:0];
                        vga_b   <= shift_b[7:0];
                        shift_r <= shift_r >> 8;
                        shift_g <= shift_g >> 8;
                        shift_b <= shift_b >> 8;
                    end
                    default: begin
                        vga_r <= '0;
                        vga_g <= '0;
                        vga_b <= '0;
                    end
                endcase

`ifdef VGA_TEST_PATTERN_EN
                // Bars override colour only; bank unpacking keeps running so merge stays in step.
                if (test_mode && active) begin
                    vga_r <= {8{h_cnt[8]}};
                    vga_g <= {8{h_cnt[7]}};
                    vga_b <= {8{h_cnt[6]}};
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench for vga_scanout on a scaled-down raster (96x10 total, 64x4 active)
// so whole frames fit in a short run; a word-level model is compared every clock.
module tb_vga_scanout;

    localparam int HA = 64, HF = 8, HS = 12, HB = 12;
    localparam int VA = 4,  VF = 2, VS = 2,  VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         pix_en = 1'b0;
    logic [127:0] r_reg_a, g_reg_a, b_reg_a, r_reg_b, g_reg_b, b_reg_b;
`ifdef VGA_TEST_PATTERN_EN
    logic         test_mode = 1'b0;
`endif
    logic         read_vga_selector;
    logic [7:0]   vga_r, vga_g, vga_b;
    logic         vga_hs, vga_vs, vga_blank_n, frame_start;
    logic [9:0]   pos_x, pos_y;

    vga_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(0)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .r_reg_a(r_reg_a), .g_reg_a(g_reg_a), .b_reg_a(b_reg_a),
        .r_reg_b(r_reg_b), .g_reg_b(g_reg_b), .b_reg_b(b_reg_b),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .read_vga_selector(read_vga_selector),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
        .pos_x(pos_x), .pos_y(pos_y), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: raster position advances per tick; each 16-pixel word is latched whole
    // from the bank chosen by a per-word alternating selector and indexed by h mod 16.
    int           mh = 0, mv = 0;
    logic         msel = 1'b0, mact;
    logic [127:0] cr = '0, cg = '0, cb = '0;
    logic [7:0]   er, eg, eb;
    logic         ehs, evs, eblank, efs;
    logic [9:0]   ex, ey;

    always @(posedge clk) begin
        if (reset) begin
            mh = 0; mv = 0; msel = 1'b0;
            er = 8'h00; eg = 8'h00; eb = 8'h00;
            ehs = 1'b1; evs = 1'b1; eblank = 1'b0; efs = 1'b0;
            ex = '0; ey = '0;
        end else begin
            efs = 1'b0;
            if (pix_en) begin
                mact   = (mh < HA) && (mv < VA);
                ex     = 10'(mh);
                ey     = 10'(mv);
                eblank = mact;
                efs    = (mh == 0) && (mv == 0);
                ehs    = !((mh >= HA + HF) && (mh < HA + HF + HS));
                evs    = !((mv >= VA + VF) && (mv < VA + VF + VS));
                if (mact) begin
                    if (mh % 16 == 0) begin
                        cr = msel ? r_reg_b : r_reg_a;
                        cg = msel ? g_reg_b : g_reg_a;
                        cb = msel ? b_reg_b : b_reg_a;
                        msel = !msel;
                    end
                    er = cr[8*(mh%16) +: 8];
                    eg = cg[8*(mh%16) +: 8];
                    eb = cb[8*(mh%16) +: 8];
                end else begin
                    er = 8'h00; eg = 8'h00; eb = 8'h00;
                end
                mh++;
                if (mh == HT) begin
                    mh = 0;
                    mv++;
                    if (mv == VT) mv = 0;
                end
            end
        end
        #1;
        chk("vga_r", {24'd0, vga_r}, {24'd0, er});
        chk("vga_g", {24'd0, vga_g}, {24'd0, eg});
        chk("vga_b", {24'd0, vga_b}, {24'd0, eb});
        chk("vga_hs", {31'd0, vga_hs}, {31'd0, ehs});
        chk("vga_vs", {31'd0, vga_vs}, {31'd0, evs});
        chk("blank_n", {31'd0, vga_blank_n}, {31'd0, eblank});
        chk("frame_start", {31'd0, frame_start}, {31'd0, efs});
        chk("pos_x", {22'd0, pos_x}, {22'd0, ex});
        chk("pos_y", {22'd0, pos_y}, {22'd0, ey});
        chk("selector", {31'd0, read_vga_selector}, {31'd0, msel});
    end

    // Observed statistics for the first continuous frame, pinned to literals afterwards.
    logic       stats_on = 1'b0;
    int         tick_cnt = 0;
    int         fs_ticks[$];
    int         hs_low_cnt = 0, hs_first = -1, hs_last = -1;
    int         vs_low_cnt = 0, vs_first = -1;
    int         tog[VT];
    logic [7:0] line_r[HA];
    logic       sel_at16 = 1'b1;

    initial for (int i = 0; i < VT; i++) tog[i] = 0;

    always @(posedge clk) begin
        logic pe, ps;
        pe = pix_en && !reset;
        ps = read_vga_selector;
        #1;
        if (stats_on && pe) begin
            tick_cnt++;
            if (frame_start) fs_ticks.push_back(tick_cnt);
            if (tick_cnt <= HT * VT) begin
                if (!vga_hs && pos_y == 10'd0) begin
                    hs_low_cnt++;
                    if (hs_first < 0) hs_first = int'(pos_x);
                    hs_last = int'(pos_x);
                end
                if (!vga_vs) begin
                    vs_low_cnt++;
                    if (vs_first < 0) vs_first = int'(pos_y);
                end
                if (read_vga_selector != ps) tog[pos_y]++;
                if (pos_y == 10'd0 && vga_blank_n) line_r[pos_x] = vga_r;
                if (pos_y == 10'd0 && pos_x == 10'd16) sel_at16 = read_vga_selector;
            end
        end
    end

    initial begin
        r_reg_a = {16{8'hAA}};
        r_reg_b = 128'h0F0E0D0C0B0A09080706050403020100;
        g_reg_a = 128'h00112233445566778899AABBCCDDEEFF;
        g_reg_b = 128'hFFEEDDCCBBAA99887766554433221100;
        b_reg_a = 128'h0123456789ABCDEFFEDCBA9876543210;
        b_reg_b = {16{8'h5A}};

        repeat (3) @(negedge clk);
        chk("rst_hs", {31'd0, vga_hs}, 32'd1);
        chk("rst_vs", {31'd0, vga_vs}, 32'd1);
        chk("rst_blank_n", {31'd0, vga_blank_n}, 32'd0);
        chk("rst_sel", {31'd0, read_vga_selector}, 32'd0);

        stats_on = 1'b1;
        reset = 1'b0;
        pix_en = 1'b1;
        repeat (1925) @(negedge clk);
        stats_on = 1'b0;

        chk("fs_count", fs_ticks.size(), 32'd3);
        chk("fs_first_tick", (fs_ticks.size() > 0) ? fs_ticks[0] : -1, 32'd1);
        chk("frame_period", (fs_ticks.size() > 1) ? fs_ticks[1] - fs_ticks[0] : 0, 32'd960);
        chk("hs_low_ticks", hs_low_cnt, 32'd12);
        chk("hs_first_x", hs_first, 32'd72);
        chk("hs_last_x", hs_last, 32'd83);
        chk("vs_low_ticks", vs_low_cnt, 32'd192);
        chk("vs_first_y", vs_first, 32'd6);
        for (int y = 0; y < VT; y++)
            chk($sformatf("toggles_line%0d", y), tog[y], (y < VA) ? 32'd4 : 32'd0);
        chk("pix_x0", {24'd0, line_r[0]}, 32'hAA);
        chk("pix_x15", {24'd0, line_r[15]}, 32'hAA);
        chk("pix_x16", {24'd0, line_r[16]}, 32'h00);
        chk("pix_x17", {24'd0, line_r[17]}, 32'h01);
        chk("pix_x31", {24'd0, line_r[31]}, 32'h0F);
        chk("pix_x32", {24'd0, line_r[32]}, 32'hAA);
        chk("pix_x48", {24'd0, line_r[48]}, 32'h00);
        chk("pix_x63", {24'd0, line_r[63]}, 32'h0F);
        chk("sel_after_x16", {31'd0, sel_at16}, 32'd0);

        // Half-rate pixel enable with bank B now a flat 0x55.
        r_reg_b = {16{8'h55}};
        repeat (2000) begin
            pix_en = ~pix_en;
            @(negedge clk);
        end

        // Mid-line reset at h=40, v=1, with a distinctive first byte in bank A.
        pix_en = 1'b1;
        for (int i = 0; i < 3000 && !(mh == 40 && mv == 1); i++) @(negedge clk);
        chk("reset_seek", {31'd0, (mh == 40 && mv == 1)}, 32'd1);
        r_reg_a = {{15{8'hAA}}, 8'h3C};
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_r", {24'd0, vga_r}, 32'd0);
        chk("mid_rst_x", {22'd0, pos_x}, 32'd0);
        chk("mid_rst_sel", {31'd0, read_vga_selector}, 32'd0);
        chk("mid_rst_hs", {31'd0, vga_hs}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_r", {24'd0, vga_r}, 32'h3C);
        chk("post_rst_x", {22'd0, pos_x}, 32'd0);
        chk("post_rst_y", {22'd0, pos_y}, 32'd0);
        chk("post_rst_fs", {31'd0, frame_start}, 32'd1);
        chk("post_rst_blank_n", {31'd0, vga_blank_n}, 32'd1);
        repeat (200) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
